// File: rtl/acondicionador_botones_pkg.sv
// -----------------------------------------------------------------------------
// botones_pkg
//
// Shared definitions for the push-button conditioner (acondicionador_botones)
// and its per-channel core (canal_boton):
//   - estado_t : per-channel FSM state encoding (3 bits)
//   - default cycle counts for a 50 MHz system clock
//   - counter-width helpers built on $clog2
//
// Optional build macro used by the users of this package: AUTO_REPEAT_EN.
// -----------------------------------------------------------------------------
package botones_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_DEB_PRESS   = 3'd1,
        ST_PRESSED     = 3'd2,
        ST_HELD        = 3'd3,
        ST_DEB_RELEASE = 3'd4
    } estado_t;

    // Defaults for 50 MHz: 20 ms debounce, 5 s hold, 1 s auto-repeat.
    localparam int unsigned DEB_CYCLES_DEF    = 32'd1000000;
    localparam int unsigned HOLD_CYCLES_DEF   = 32'd250000000;
    localparam int unsigned REPEAT_CYCLES_DEF = 32'd50000000;

    // Width of a counter that must hold the values 0 .. n-1.
    // Never returns 0 so that n == 1 still yields a legal 1-bit vector.
    function automatic int unsigned ancho_contador(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Hold/repeat counter shares one register, so it is sized for the larger.
    function automatic int unsigned ancho_hold(input int unsigned hold_c,
                                               input int unsigned rep_c);
        return ancho_contador((hold_c > rep_c) ? hold_c : rep_c);
    endfunction

endpackage

// File: rtl/acondicionador_botones_canal_boton.sv
// -----------------------------------------------------------------------------
// canal_boton
//
// One push-button channel: 2-FF synchroniser, debounce FSM, hold timer and
// registered level / pulse outputs.
//
// The input is already polarity-normalised (1 = pressed), so the synchroniser
// resets to 0, i.e. the inactive level, and no press is seen after reset.
//
// Ports:
//   clk       : system clock
//   reset     : asynchronous reset, active low
//   i_btn     : raw normalised button (asynchronous to clk)
//   o_level   : debounced pressed level
//   o_press   : 1-cycle pulse on accepted press
//   o_release : 1-cycle pulse on accepted release
//   o_hold    : 1-cycle pulse when the hold time elapses
//
// Build macro: AUTO_REPEAT_EN -- when defined, o_hold repeats every
// REPEAT_CYCLES cycles while the button stays held.
// -----------------------------------------------------------------------------
module canal_boton
    import botones_pkg::*;
#(
    parameter int unsigned DEB_CYCLES    = DEB_CYCLES_DEF,
    parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_hold
);

    localparam int unsigned DW = ancho_contador(DEB_CYCLES);
    localparam int unsigned HW = ancho_hold(HOLD_CYCLES, REPEAT_CYCLES);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
`ifdef AUTO_REPEAT_EN
    localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);
`endif

    // Synchroniser
    logic r_sync1;
    logic r_sync2;
    logic w_s;

    // FSM state, counters and registered outputs
    estado_t       r_estado;
    estado_t       w_estado_sig;
    logic [DW-1:0] r_dcnt;
    logic [DW-1:0] w_dcnt_sig;
    logic [HW-1:0] r_hcnt;
    logic [HW-1:0] w_hcnt_sig;
    logic          r_held;
    logic          w_held_sig;
    logic          r_level;
    logic          w_level_sig;
    logic          r_press;
    logic          w_press_sig;
    logic          r_release;
    logic          w_release_sig;
    logic          r_hold;
    logic          w_hold_sig;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_estado  <= ST_IDLE;
            r_dcnt    <= '0;
            r_hcnt    <= '0;
            r_held    <= 1'b0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_hold    <= 1'b0;
        end else begin
            r_estado  <= w_estado_sig;
            r_dcnt    <= w_dcnt_sig;
            r_hcnt    <= w_hcnt_sig;
            r_held    <= w_held_sig;
            r_level   <= w_level_sig;
            r_press   <= w_press_sig;
            r_release <= w_release_sig;
            r_hold    <= w_hold_sig;
        end
    end

    always_comb begin
        w_estado_sig  = r_estado;
        w_dcnt_sig    = r_dcnt;
        w_hcnt_sig    = r_hcnt;
        w_held_sig    = r_held;
        w_press_sig   = 1'b0;
        w_release_sig = 1'b0;
        w_hold_sig    = 1'b0;

        unique case (r_estado)
            ST_IDLE: begin
                if (w_s) begin
                    w_estado_sig = ST_DEB_PRESS;
                    w_dcnt_sig   = '0;
                end
            end

            ST_DEB_PRESS: begin
                if (!w_s) begin
                    w_estado_sig = ST_IDLE;
                end else if (r_dcnt == DEB_LAST) begin
                    w_estado_sig = ST_PRESSED;
                    w_press_sig  = 1'b1;
                    w_hcnt_sig   = '0;
                end else begin
                    w_dcnt_sig = r_dcnt + 1'b1;
                end
            end

            ST_PRESSED: begin
                // hcnt is deliberately not cleared on the way to DEB_RELEASE:
                // a release glitch only pauses the hold timer.
                if (!w_s) begin
                    w_estado_sig = ST_DEB_RELEASE;
                    w_dcnt_sig   = '0;
                end else if (r_hcnt == HOLD_LAST) begin
                    w_estado_sig = ST_HELD;
                    w_hold_sig   = 1'b1;
                    w_held_sig   = 1'b1;
`ifdef AUTO_REPEAT_EN
                    w_hcnt_sig   = '0;
`endif
                end else begin
                    w_hcnt_sig = r_hcnt + 1'b1;
                end
            end

            ST_HELD: begin
                if (!w_s) begin
                    w_estado_sig = ST_DEB_RELEASE;
                    w_dcnt_sig   = '0;
                end
`ifdef AUTO_REPEAT_EN
                else if (r_hcnt == REP_LAST) begin
                    w_hold_sig = 1'b1;
                    w_hcnt_sig = '0;
                end else begin
                    w_hcnt_sig = r_hcnt + 1'b1;
                end
`endif
            end

            ST_DEB_RELEASE: begin
                // r_held tells which pressed state to resume after a glitch.
                if (w_s) begin
                    w_estado_sig = r_held ? ST_HELD : ST_PRESSED;
                end else if (r_dcnt == DEB_LAST) begin
                    w_estado_sig  = ST_IDLE;
                    w_release_sig = 1'b1;
                    w_held_sig    = 1'b0;
                end else begin
                    w_dcnt_sig = r_dcnt + 1'b1;
                end
            end

            default: begin
                w_estado_sig = ST_IDLE;
                w_held_sig   = 1'b0;
            end
        endcase

        w_level_sig = (w_estado_sig == ST_PRESSED) ||
                      (w_estado_sig == ST_HELD)    ||
                      (w_estado_sig == ST_DEB_RELEASE);
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_hold    = r_hold;

endmodule

// File: rtl/acondicionador_botones.sv
// -----------------------------------------------------------------------------
// acondicionador_botones
//
// Push-button front end for the modes/levels block. Each of N_BOTONES raw,
// asynchronous, bouncing button pins is synchronised and debounced, giving a
// clean level plus 1-cycle press, release and long-hold pulses. btn_hold
// drives the 5-second inputs of the modes block.
//
// Ports:
//   clk         : system clock
//   reset       : asynchronous reset, active low (0 = in reset)
//   btn_raw     : raw button pins, asynchronous to clk
//   btn_level   : debounced pressed level per channel
//   btn_press   : 1-cycle pulse on accepted press
//   btn_release : 1-cycle pulse on accepted release
//   btn_hold    : 1-cycle pulse when HOLD_CYCLES pressed cycles have elapsed
//
// Build macro: AUTO_REPEAT_EN -- when defined, btn_hold repeats every
// REPEAT_CYCLES cycles while a button remains held.
// -----------------------------------------------------------------------------
module acondicionador_botones
    import botones_pkg::*;
#(
    parameter int unsigned N_BOTONES      = 2,
    parameter int unsigned BTN_ACTIVE_LOW = 1,
    parameter int unsigned DEB_CYCLES     = DEB_CYCLES_DEF,
    parameter int unsigned HOLD_CYCLES    = HOLD_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES  = REPEAT_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_BOTONES-1:0] btn_raw,
    output logic [N_BOTONES-1:0] btn_level,
    output logic [N_BOTONES-1:0] btn_press,
    output logic [N_BOTONES-1:0] btn_release,
    output logic [N_BOTONES-1:0] btn_hold
);

    // Inverting a single asynchronous bit ahead of the synchroniser is
    // equivalent to normalising after it, and lets every channel reset its
    // synchroniser to 0 (the inactive level).
    localparam logic [N_BOTONES-1:0] POL_MASK =
        (BTN_ACTIVE_LOW != 0) ? {N_BOTONES{1'b1}} : {N_BOTONES{1'b0}};

    logic [N_BOTONES-1:0] w_btn_norm;

    assign w_btn_norm = btn_raw ^ POL_MASK;

    for (genvar g = 0; g < N_BOTONES; g++) begin : g_canal
        canal_boton #(
            .DEB_CYCLES    (DEB_CYCLES),
            .HOLD_CYCLES   (HOLD_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_canal (
            .clk       (clk),
            .reset     (reset),
            .i_btn     (w_btn_norm[g]),
            .o_level   (btn_level[g]),
            .o_press   (btn_press[g]),
            .o_release (btn_release[g]),
            .o_hold    (btn_hold[g])
        );
    end

endmodule

// File: tb/tb_acondicionador_botones.sv
module tb_acondicionador_botones;

    logic       clk;
    logic       reset;
    logic [1:0] btn_raw;
    logic [1:0] btn_level;
    logic [1:0] btn_press;
    logic [1:0] btn_release;
    logic [1:0] btn_hold;

    int n_chk;
    int n_fail;
    int cyc;

    // Cycle stamps of every pulse, per channel.
    int q_p0[$];
    int q_p1[$];
    int q_r0[$];
    int q_r1[$];
    int q_h0[$];
    int q_h1[$];
    int n_lvl0;

    acondicionador_botones #(
        .N_BOTONES      (2),
        .BTN_ACTIVE_LOW (0),
        .DEB_CYCLES     (4),
        .HOLD_CYCLES    (20),
        .REPEAT_CYCLES  (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_hold    (btn_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (btn_press[0])   q_p0.push_back(cyc);
        if (btn_press[1])   q_p1.push_back(cyc);
        if (btn_release[0]) q_r0.push_back(cyc);
        if (btn_release[1]) q_r1.push_back(cyc);
        if (btn_hold[0])    q_h0.push_back(cyc);
        if (btn_hold[1])    q_h1.push_back(cyc);
        if (btn_level[0])   n_lvl0 = n_lvl0 + 1;
    end

    task automatic clear_log();
        q_p0.delete(); q_p1.delete();
        q_r0.delete(); q_r1.delete();
        q_h0.delete(); q_h1.delete();
        n_lvl0 = 0;
    endtask

    // Called at a falling edge; advances to the falling edge after edge c.
    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Called at a falling edge; e0 is the edge that first samples the value.
    task automatic set_raw(input logic [1:0] v, output int e0);
        btn_raw = v;
        e0 = cyc + 1;
    endtask

    task automatic test_reset();
        reset   = 1'b0;
        btn_raw = 2'b00;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({btn_level, btn_press, btn_release, btn_hold} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b exp=00000000",
                     {btn_level, btn_press, btn_release, btn_hold});
        end
        reset = 1'b1;
        clear_log();
        repeat (10) @(negedge clk);
        n_chk++;
        if (q_p0.size() + q_p1.size() + q_h0.size() + q_h1.size() + n_lvl0 != 0) begin
            n_fail++;
            $display("FAIL reset_quiet got=%0d events exp=0",
                     q_p0.size() + q_p1.size() + q_h0.size() + q_h1.size() + n_lvl0);
        end
    endtask

    task automatic test_clean_press();
        int e0, r0, hv, nh_exp;
        @(negedge clk);
        clear_log();
        set_raw(2'b01, e0);
        wait_to(e0 + 5);
        n_chk++;
        if ({btn_level[0], btn_press[0]} !== 2'b00) begin
            n_fail++;
            $display("FAIL press_early got=%b exp=00", {btn_level[0], btn_press[0]});
        end
        wait_to(e0 + 6);
        n_chk++;
        if ({btn_level, btn_press} !== 4'b0101) begin
            n_fail++;
            $display("FAIL press_edge6 got=%b exp=0101", {btn_level, btn_press});
        end
        wait_to(e0 + 7);
        n_chk++;
        if ({btn_level[0], btn_press[0]} !== 2'b10) begin
            n_fail++;
            $display("FAIL press_one_cycle got=%b exp=10", {btn_level[0], btn_press[0]});
        end
        wait_to(e0 + 39);
        hv = (q_h0.size() > 0) ? q_h0[0] : -1;
        n_chk++;
        if (hv != e0 + 26) begin
            n_fail++;
            $display("FAIL hold_time got=%0d exp=%0d", hv, e0 + 26);
        end
        n_chk++;
        if (q_p0.size() != 1 || q_p1.size() + q_h1.size() + q_r1.size() != 0 ||
            btn_level[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL press_counts got=p0:%0d ch1:%0d exp=p0:1 ch1:0",
                     q_p0.size(), q_p1.size() + q_h1.size() + q_r1.size());
        end
        wait_to(e0 + 40);
        set_raw(2'b00, r0);
        wait_to(r0 + 6);
        n_chk++;
        if ({btn_level[0], btn_release[0]} !== 2'b01) begin
            n_fail++;
            $display("FAIL release_edge6 got=%b exp=01", {btn_level[0], btn_release[0]});
        end
        wait_to(r0 + 12);
`ifdef AUTO_REPEAT_EN
        nh_exp = 3;
`else
        nh_exp = 1;
`endif
        n_chk++;
        if (q_h0.size() != nh_exp || q_r0.size() != 1) begin
            n_fail++;
            $display("FAIL clean_counts got=h:%0d r:%0d exp=h:%0d r:1",
                     q_h0.size(), q_r0.size(), nh_exp);
        end
    endtask

    task automatic test_bounce();
        int e0;
        logic [1:0] pat [4];
        pat[0] = 2'b01; pat[1] = 2'b00; pat[2] = 2'b01; pat[3] = 2'b00;
        @(negedge clk);
        clear_log();
        for (int i = 0; i < 4; i++) begin
            set_raw(pat[i], e0);
            @(negedge clk);
        end
        repeat (10) @(negedge clk);
        n_chk++;
        if (q_p0.size() + q_r0.size() + q_h0.size() + n_lvl0 != 0) begin
            n_fail++;
            $display("FAIL bounce_toggle got=%0d events exp=0",
                     q_p0.size() + q_r0.size() + q_h0.size() + n_lvl0);
        end
        set_raw(2'b01, e0);
        wait_to(e0 + 3);
        set_raw(2'b00, e0);
        repeat (12) @(negedge clk);
        n_chk++;
        if (q_p0.size() + n_lvl0 != 0) begin
            n_fail++;
            $display("FAIL bounce_short got=%0d events exp=0", q_p0.size() + n_lvl0);
        end
    endtask

    task automatic test_release_glitch();
        int e0, a0, r0, hv, dummy;
        @(negedge clk);
        clear_log();
        set_raw(2'b01, e0);
        wait_to(e0 + 9);
        set_raw(2'b00, a0);
        wait_to(e0 + 11);
        set_raw(2'b01, dummy);
        wait_to(e0 + 13);
        n_chk++;
        if (btn_level[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_level got=%b exp=1", btn_level[0]);
        end
        wait_to(e0 + 35);
        hv = (q_h0.size() > 0) ? q_h0[0] : -1;
        n_chk++;
        if (hv != e0 + 29) begin
            n_fail++;
            $display("FAIL glitch_hold_time got=%0d exp=%0d", hv, e0 + 29);
        end
        n_chk++;
        if (q_r0.size() != 0 || q_p0.size() != 1) begin
            n_fail++;
            $display("FAIL glitch_pulses got=r:%0d p:%0d exp=r:0 p:1", q_r0.size(), q_p0.size());
        end
        set_raw(2'b00, r0);
        wait_to(r0 + 5);
        n_chk++;
        if ({btn_level[0], btn_release[0]} !== 2'b10) begin
            n_fail++;
            $display("FAIL release_early got=%b exp=10", {btn_level[0], btn_release[0]});
        end
        wait_to(r0 + 6);
        n_chk++;
        if ({btn_level[0], btn_release[0]} !== 2'b01) begin
            n_fail++;
            $display("FAIL glitch_release got=%b exp=01", {btn_level[0], btn_release[0]});
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_simultaneous();
        int e0, r0;
        @(negedge clk);
        clear_log();
        set_raw(2'b11, e0);
        wait_to(e0 + 6);
        n_chk++;
        if (btn_press !== 2'b11) begin
            n_fail++;
            $display("FAIL simul_press got=%b exp=11", btn_press);
        end
        wait_to(e0 + 26);
        n_chk++;
        if (btn_hold !== 2'b11) begin
            n_fail++;
            $display("FAIL simul_hold got=%b exp=11", btn_hold);
        end
        wait_to(e0 + 30);
        set_raw(2'b00, r0);
        wait_to(r0 + 6);
        n_chk++;
        if ({btn_level, btn_release} !== 4'b0011) begin
            n_fail++;
            $display("FAIL simul_release got=%b exp=0011", {btn_level, btn_release});
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset_mid_hold();
        int e0, e1;
        @(negedge clk);
        clear_log();
        set_raw(2'b01, e0);
        wait_to(e0 + 30);
        n_chk++;
        if (btn_level !== 2'b01) begin
            n_fail++;
            $display("FAIL held_level got=%b exp=01", btn_level);
        end
        reset = 1'b0;
        #1;
        n_chk++;
        if ({btn_level, btn_press, btn_release, btn_hold} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_async got=%b exp=00000000",
                     {btn_level, btn_press, btn_release, btn_hold});
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        e1 = cyc + 1;
        wait_to(e1 + 5);
        n_chk++;
        if (btn_press[0] !== 1'b0 || q_p0.size() != 1) begin
            n_fail++;
            $display("FAIL rst_press_early got=%b/%0d exp=0/1", btn_press[0], q_p0.size());
        end
        wait_to(e1 + 6);
        n_chk++;
        if (btn_press !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_press_again got=%b exp=01", btn_press);
        end
        n_chk++;
        if (q_r0.size() != 0) begin
            n_fail++;
            $display("FAIL rst_no_release got=%0d exp=0", q_r0.size());
        end
        set_raw(2'b00, e0);
        repeat (10) @(negedge clk);
    endtask

    task automatic test_hold_series();
        int e0, r0, rv;
`ifdef AUTO_REPEAT_EN
        int exp_h[5] = '{26, 34, 42, 50, 58};
        int n_exp = 5;
`else
        int exp_h[1] = '{26};
        int n_exp = 1;
`endif
        @(negedge clk);
        clear_log();
        set_raw(2'b01, e0);
        wait_to(e0 + 59);
        set_raw(2'b00, r0);
        wait_to(r0 + 12);
        n_chk++;
        if (q_h0.size() != n_exp) begin
            n_fail++;
            $display("FAIL hold_count got=%0d exp=%0d", q_h0.size(), n_exp);
        end
        for (int i = 0; i < n_exp; i++) begin
            rv = (q_h0.size() > i) ? q_h0[i] : -1;
            n_chk++;
            if (rv != e0 + exp_h[i]) begin
                n_fail++;
                $display("FAIL hold_pulse%0d got=%0d exp=%0d", i, rv, e0 + exp_h[i]);
            end
        end
        rv = (q_r0.size() > 0) ? q_r0[0] : -1;
        n_chk++;
        if (rv != e0 + 66) begin
            n_fail++;
            $display("FAIL hold_release got=%0d exp=%0d", rv, e0 + 66);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        n_lvl0 = 0;
        reset   = 1'b0;
        btn_raw = 2'b00;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_glitch();
        test_simultaneous();
        test_reset_mid_hold();
        test_hold_series();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
